// File: rtl/rlnn_serdes_pkg.sv
// Shared types and helpers for the rlnn serializer/deserializer pair.
// Used by the PISO datapath and the SIPO-side controller.
package rlnn_serdes_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } serdes_state_t;

    // Beat counter width; a 1-element vector still needs a 1-bit counter.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in serial-out vector serializer, MSB element first, valid/ready output stream.
// Latency: load fire at edge N -> first element valid in cycle N+1; one element per beat fire.
// Backpressure: out_ready=0 holds the element (out_valid never retracts); reload only on last beat.
module piso_serializer
    import rlnn_serdes_pkg::*;
#(
    parameter int COUNT      = 128,
    parameter int DATA_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_b,
    input  logic                          clear,
    input  logic                          load_valid,
    output logic                          load_ready,
    input  logic [DATA_WIDTH*COUNT-1:0]   A_in,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_WIDTH-1:0]         A_out,
    output logic                          out_last,
    output logic                          busy
);

    localparam int                VEC_W    = DATA_WIDTH * COUNT;
    localparam int                CNT_W    = cnt_w(COUNT);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(COUNT - 1);

    serdes_state_t    state;
    logic [CNT_W-1:0] cnt;
    logic [VEC_W-1:0] shift_reg;

    logic load_fire;
    logic beat_fire;

    // out_ready feeds load_ready combinationally so a new vector can follow the last beat with no bubble.
    always_comb begin
        out_valid  = 1'b0;
        busy       = 1'b0;
        out_last   = 1'b0;
        load_ready = 1'b0;
        load_fire  = 1'b0;
        beat_fire  = 1'b0;

        out_valid  = (state == SEND);
        busy       = (state == SEND);
        out_last   = (state == SEND) && (cnt == LAST_CNT);
        load_ready = !clear && ((state == IDLE) || (out_last && out_ready));
        load_fire  = load_valid && load_ready;
        beat_fire  = out_valid && out_ready;
    end

    // Zero fill keeps A_out at 0 once the vector has drained back to IDLE.
    assign A_out = shift_reg[VEC_W-1 -: DATA_WIDTH];

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state     <= IDLE;
            cnt       <= '0;
            shift_reg <= '0;
        end else if (clear) begin
            state     <= IDLE;
            cnt       <= '0;
            shift_reg <= '0;
        end else if (load_fire) begin
            state     <= SEND;
            cnt       <= '0;
            shift_reg <= A_in;
        end else if (beat_fire) begin
            shift_reg <= shift_reg << DATA_WIDTH;
            if (out_last) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                cnt   <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer with COUNT=4, DATA_WIDTH=16 and a SIPO loopback model.
module tb_piso_serializer;

    localparam int COUNT = 4;
    localparam int DW    = 16;

    logic              clk;
    logic              rst_b;
    logic              clear;
    logic              load_valid;
    logic              load_ready;
    logic [DW*COUNT-1:0] A_in;
    logic              out_valid;
    logic              out_ready;
    logic [DW-1:0]     A_out;
    logic              out_last;
    logic              busy;

    int errors;
    int checks;

    localparam logic [63:0] VEC1 = 64'h0004_0003_0002_0001;
    localparam logic [63:0] VEC2 = 64'h0008_0007_0006_0005;

    piso_serializer #(
        .COUNT      (COUNT),
        .DATA_WIDTH (DW)
    ) dut (
        .clk        (clk),
        .rst_b      (rst_b),
        .clear      (clear),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .A_in       (A_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .A_out      (A_out),
        .out_last   (out_last),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present vec for one cycle with out_ready=1; returns one cycle after the load edge.
    task automatic load_vec(input logic [63:0] vec, input string tag);
        A_in       = vec;
        load_valid = 1'b1;
        out_ready  = 1'b1;
        #1;
        chk({tag, "_load_ready"}, 64'(load_ready), 64'd1);
        tick();
        load_valid = 1'b0;
    endtask

    // Drains a full vector at full rate, checking each element and the rebuilt SIPO word.
    task automatic expect_beats(input logic [63:0] vec, input string tag);
        logic [63:0] sipo;
        logic [15:0] exp_el;
        sipo      = '0;
        out_ready = 1'b1;
        for (int i = 0; i < COUNT; i++) begin
            exp_el = vec[63 - 16*i -: 16];
            chk($sformatf("%s_valid%0d", tag, i), 64'(out_valid), 64'd1);
            chk($sformatf("%s_data%0d", tag, i), 64'(A_out), 64'(exp_el));
            chk($sformatf("%s_last%0d", tag, i), 64'(out_last), (i == COUNT-1) ? 64'd1 : 64'd0);
            sipo = {sipo[47:0], A_out};
            tick();
        end
        chk({tag, "_idle_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_idle_data"}, 64'(A_out), 64'd0);
        chk({tag, "_sipo"}, sipo, vec);
    endtask

    initial begin
        errors     = 0;
        checks     = 0;
        rst_b      = 1'b0;
        clear      = 1'b0;
        load_valid = 1'b0;
        out_ready  = 1'b0;
        A_in       = '0;

        // Reset values
        tick();
        tick();
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_data", 64'(A_out), 64'd0);
        chk("rst_last", 64'(out_last), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_load_ready", 64'(load_ready), 64'd1);
        rst_b = 1'b1;
        tick();

        // Basic serialization and loopback
        load_vec(VEC1, "basic");
        chk("basic_busy", 64'(busy), 64'd1);
        expect_beats(VEC1, "basic");

        // Backpressure while 0003 is presented
        load_vec(VEC1, "bp");
        chk("bp_d0", 64'(A_out), 64'h4);
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("bp_hold_data%0d", i), 64'(A_out), 64'h3);
            chk($sformatf("bp_hold_valid%0d", i), 64'(out_valid), 64'd1);
            tick();
        end
        out_ready = 1'b1;
        chk("bp_resume_d1", 64'(A_out), 64'h3);
        tick();
        chk("bp_resume_d2", 64'(A_out), 64'h2);
        tick();
        chk("bp_resume_d3", 64'(A_out), 64'h1);
        chk("bp_resume_last", 64'(out_last), 64'd1);
        tick();
        chk("bp_done_valid", 64'(out_valid), 64'd0);

        // Back-to-back vectors; A_in changes after capture must not matter
        A_in       = VEC1;
        load_valid = 1'b1;
        out_ready  = 1'b1;
        tick();
        A_in = VEC2;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("b2b_d%0d", i), 64'(A_out), 64'(4 - i));
            chk($sformatf("b2b_no_ready%0d", i), 64'(load_ready), 64'd0);
            tick();
        end
        #1;
        chk("b2b_last_data", 64'(A_out), 64'h1);
        chk("b2b_last_flag", 64'(out_last), 64'd1);
        chk("b2b_last_load_ready", 64'(load_ready), 64'd1);
        tick();
        load_valid = 1'b0;
        expect_beats(VEC2, "b2b_second");

        // Clear beats a simultaneous load
        load_vec(VEC1, "clr");
        tick();
        tick();
        chk("clr_pre_data", 64'(A_out), 64'h2);
        clear      = 1'b1;
        load_valid = 1'b1;
        A_in       = VEC2;
        #1;
        chk("clr_load_ready", 64'(load_ready), 64'd0);
        tick();
        clear      = 1'b0;
        load_valid = 1'b0;
        chk("clr_valid", 64'(out_valid), 64'd0);
        chk("clr_busy", 64'(busy), 64'd0);
        chk("clr_data", 64'(A_out), 64'd0);
        tick();
        chk("clr_not_captured", 64'(out_valid), 64'd0);
        load_vec(VEC1, "clr_reload");
        expect_beats(VEC1, "clr_reload");

        // Asynchronous reset mid-vector
        load_vec(VEC1, "arst");
        tick();
        chk("arst_pre_data", 64'(A_out), 64'h3);
        #2;
        rst_b = 1'b0;
        #1;
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_data", 64'(A_out), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_last", 64'(out_last), 64'd0);
        chk("arst_load_ready", 64'(load_ready), 64'd1);
        tick();
        rst_b = 1'b1;
        tick();
        load_vec(VEC1, "arst_reload");
        expect_beats(VEC1, "arst_reload");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
